// File: rtl/stepper_cmd_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// stepper_pkg
//   Shared types and constants for the stepper command sequencer: the issue
//   FSM state encoding, the command word field layout, the abort command and
//   a helper that sizes the shared wait/settle timer.
// ---------------------------------------------------------------------------
package stepper_pkg;

    // Issue FSM states
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        SETTLE
    } seq_state_t;

    // Command word layout: [22:21] mode, [20:0] target position
    localparam int MODE_MSB = 22;
    localparam int MODE_LSB = 21;
    localparam int POS_W    = 21;

    // Mode value that zeroes/disables the Stepper
    localparam logic [1:0] MODE_ZERO = 2'b11;

    // Zero/disable command with target 0, forced out on abort
    localparam logic [31:0] ABORT_CMD = 32'h0060_0000;

    // Width of one counter able to reach both the start timeout and the
    // settle period; never narrower than one bit.
    function automatic int timer_width(input int start_timeout, input int settle_cycles);
        int longest;
        longest = (start_timeout > settle_cycles) ? start_timeout : settle_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/stepper_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// stepper_cmd_sequencer_if
//   Bundles the two requester handshakes, the abort pulse, the Stepper side
//   (busy in, data/new_data out) and the status outputs of the sequencer.
//   Modports:
//     master : requesters / Stepper model side (drives valid, data, abort,
//              stepper_busy; observes readys, command and status)
//     slave  : the sequencer itself
//   DEPTH must match the sequencer's DEPTH so fifo_count widths line up.
// ---------------------------------------------------------------------------
interface stepper_cmd_sequencer_if #(
    parameter int DEPTH = 4
);
    localparam int COUNT_W = $clog2(DEPTH) + 1;

    logic               req0_valid;
    logic [31:0]        req0_data;
    logic               req0_ready;
    logic               req1_valid;
    logic [31:0]        req1_data;
    logic               req1_ready;
    logic               abort;
    logic               stepper_busy;
    logic [31:0]        cmd_data;
    logic               cmd_new_data;
    logic [COUNT_W-1:0] fifo_count;
    logic               idle;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, abort, stepper_busy,
        input  req0_ready, req1_ready, cmd_data, cmd_new_data, fifo_count, idle
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, abort, stepper_busy,
        output req0_ready, req1_ready, cmd_data, cmd_new_data, fifo_count, idle
    );

endinterface

// File: rtl/stepper_cmd_sequencer_cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
//   Synchronous DEPTH x WIDTH command queue with occupancy count.
//   Ports:
//     clk, reset      : clock and synchronous active-high reset
//     clear           : synchronous flush (pointers and count to zero)
//     push, push_data : write one entry (caller guarantees not full)
//     pop             : drop the head entry (caller guarantees not empty)
//     head            : current head entry, valid while !empty
//     count           : occupied entries, wide enough to hold DEPTH
//     full, empty     : occupancy flags
// ---------------------------------------------------------------------------
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage array is not reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
    // push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule

// File: rtl/stepper_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// stepper_cmd_sequencer
//   Queues motion commands from two requesters (0 = CPU MMIO, 1 = aux/homing)
//   through a round-robin arbiter into a small FIFO, then issues them one at a
//   time to the Stepper, waiting for the move to start, finish and settle.
//   Ports:
//     CLK100MHZ : system clock, all logic on posedge
//     reset     : synchronous, active-high
//     bus       : slave modport carrying req0/req1 valid/data/ready, abort,
//                 stepper_busy, cmd_data, cmd_new_data, fifo_count, idle
// ---------------------------------------------------------------------------
module stepper_cmd_sequencer
    import stepper_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int START_TIMEOUT = 16,
    parameter int SETTLE_CYCLES = 1000000
) (
    input  logic                     CLK100MHZ,
    input  logic                     reset,
    stepper_cmd_sequencer_if.slave   bus
);
    localparam int COUNT_W = $clog2(DEPTH) + 1;
    localparam int TIMER_W = timer_width(START_TIMEOUT, SETTLE_CYCLES);
    localparam logic [TIMER_W-1:0] START_LAST  = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);

    seq_state_t          state;
    logic [TIMER_W-1:0]  timer;
    logic [31:0]         cmd_data;
    logic                cmd_new_data;
    logic                rr_ptr;
    logic                grant;
    logic                push;
    logic [31:0]         push_data;
    logic                pop;
    logic [31:0]         fifo_head;
    logic [COUNT_W-1:0]  fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    // Requester 1 wins when it is the only one asking, or when both ask and
    // the round-robin pointer favours it; otherwise requester 0 holds grant.
    assign grant = bus.req1_valid && (!bus.req0_valid || rr_ptr);

    // Readys are combinational so a requester learns acceptance in the same
    // cycle; abort and reset both suppress them so nothing sneaks in.
    assign bus.req0_ready = !reset && !fifo_full && !grant && !bus.abort;
    assign bus.req1_ready = !reset && !fifo_full &&  grant && !bus.abort;

    assign push      = (bus.req0_valid && bus.req0_ready) ||
                       (bus.req1_valid && bus.req1_ready);
    assign push_data = grant ? bus.req1_data : bus.req0_data;

    // The FSM only drains the queue from IDLE, and never on an abort cycle
    // since the queue is being flushed then.
    assign pop = (state == IDLE) && !fifo_empty && !bus.abort;

    // Round-robin pointer toggles after every accepted push.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (push) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_cmd_fifo (
        .clk       (CLK100MHZ),
        .reset     (reset),
        .clear     (bus.abort),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Issue FSM. cmd_data is loaded one cycle before the new_data pulse so
    // the Stepper's negedge capture sees a stable word. One timer serves both
    // the start timeout and the settle period since they never overlap.
    // Abort outranks everything except reset and always re-enters ISSUE.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            cmd_data     <= '0;
            cmd_new_data <= 1'b0;
        end else if (bus.abort) begin
            state        <= ISSUE;
            timer        <= '0;
            cmd_data     <= ABORT_CMD;
            cmd_new_data <= 1'b0;
        end else begin
            cmd_new_data <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cmd_data <= fifo_head;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cmd_new_data <= 1'b1;
                    timer        <= '0;
                    state        <= WAIT_START;
                end
                WAIT_START: begin
                    if (bus.stepper_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == START_LAST) begin
                        timer <= '0;
                        state <= SETTLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.stepper_busy) begin
                        timer <= '0;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (timer == SETTLE_LAST) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_data     = cmd_data;
    assign bus.cmd_new_data = cmd_new_data;
    assign bus.fifo_count   = fifo_count;
    assign bus.idle         = fifo_empty && (state == IDLE);

endmodule

// File: tb/tb_stepper_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stepper_cmd_sequencer
//   Scoreboard bench: directed stimulus pushes the expected issued command
//   words into a queue; a negedge monitor pops and compares on every
//   cmd_new_data pulse and logs the cycle of each pulse for timing checks.
// ---------------------------------------------------------------------------
module tb_stepper_cmd_sequencer;
    import stepper_pkg::*;

    localparam int DEPTH         = 4;
    localparam int START_TIMEOUT = 16;
    localparam int SETTLE_CYCLES = 20;

    logic CLK100MHZ = 1'b0;
    logic reset;

    always #5 CLK100MHZ = ~CLK100MHZ;

    stepper_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

    stepper_cmd_sequencer #(
        .DEPTH         (DEPTH),
        .START_TIMEOUT (START_TIMEOUT),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [31:0] exp_q [$];
    int          pulse_count = 0;
    int          pulse_cycles [$];

    // Cycle index = number of rising edges seen so far
    always @(posedge CLK100MHZ) cycle <= cycle + 1;

    // Scoreboard monitor: every new_data pulse must match the next expected word
    always @(negedge CLK100MHZ) begin
        if (bus.cmd_new_data) begin
            logic [31:0] exp_word;
            pulse_count++;
            pulse_cycles.push_back(cycle);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pulse cmd_data=%h expected no pulse (cycle %0d)",
                         bus.cmd_data, cycle);
            end else begin
                exp_word = exp_q.pop_front();
                if (bus.cmd_data !== exp_word) begin
                    errors++;
                    $display("[TB] FAIL issued_cmd actual=%h expected=%h (cycle %0d)",
                             bus.cmd_data, exp_word, cycle);
                end
            end
        end
    end

    // Watchdog so the run always ends even if a wait logic slips
    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic setReq(input int rq, input logic valid, input logic [31:0] data);
        if (rq == 0) begin
            bus.req0_valid = valid;
            bus.req0_data  = data;
        end else begin
            bus.req1_valid = valid;
            bus.req1_data  = data;
        end
    endtask

    // Offer one command and hold it until accepted; returns the cycle index
    // of the accepting edge.
    task automatic applyStimulus(input int rq, input logic [31:0] data, output int acc_cycle);
        int  waited;
        logic ok;
        waited = 0;
        ok     = 1'b0;
        setReq(rq, 1'b1, data);
        while (!ok && waited < 300) begin
            @(negedge CLK100MHZ);
            ok = (rq == 0) ? bus.req0_ready : bus.req1_ready;
            waited++;
        end
        if (ok) begin
            @(posedge CLK100MHZ);
            #1;
            acc_cycle = cycle;
        end else begin
            acc_cycle = -1;
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout req%0d data=%h never accepted, expected acceptance", rq, data);
        end
        setReq(rq, 1'b0, 32'h0);
    endtask

    task automatic waitCycle(input int target);
        while (cycle < target) begin
            @(posedge CLK100MHZ);
            #1;
        end
    endtask

    task automatic waitPulses(input int n, input int budget, input string name);
        int waited;
        waited = 0;
        while (pulse_count < n && waited < budget) begin
            @(posedge CLK100MHZ);
            #1;
            waited++;
        end
        checks++;
        if (pulse_count < n) begin
            errors++;
            $display("[TB] FAIL %s pulses=%0d expected %0d within %0d cycles", name, pulse_count, n, budget);
        end
    endtask

    task automatic waitIdle(input int budget, input string name);
        int waited;
        waited = 0;
        while (!bus.idle && waited < budget) begin
            @(posedge CLK100MHZ);
            #1;
            waited++;
        end
        checkOutput(name, bus.idle, 1'b1);
        checkOutput({name, "_count"}, 32'(bus.fifo_count), 32'd0);
    endtask

    initial begin
        int c0, c1, c2, c3, c4, base, p, a;
        int acc0 [6];
        int acc1 [6];
        logic done0, done1, saw_full;

        reset            = 1'b1;
        bus.req0_valid   = 1'b0;
        bus.req0_data    = 32'h0;
        bus.req1_valid   = 1'b0;
        bus.req1_data    = 32'h0;
        bus.abort        = 1'b0;
        bus.stepper_busy = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
        checkOutput("rst_count",    32'(bus.fifo_count), 32'd0);
        checkOutput("rst_idle",     bus.idle, 1'b1);
        checkOutput("rst_cmd_data", bus.cmd_data, 32'h0);
        checkOutput("rst_new_data", bus.cmd_new_data, 1'b0);
        checkOutput("rst_ready0",   bus.req0_ready, 1'b0);
        checkOutput("rst_ready1",   bus.req1_ready, 1'b0);
        reset = 1'b0;
        waitCycle(cycle + 1);

        // Test 1: single move with busy, then next issue after settle.
        // Pulse P: busy seen from P+3, first quiet edge F=P+13,
        // IDLE at F+20, pop at F+21, pulse at F+22 = P+35.
        $display("[TB] test 1: single move with busy and settle");
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0200);
        base = pulse_count;
        applyStimulus(0, 32'h0000_0100, c0);
        applyStimulus(0, 32'h0000_0200, c1);
        checkOutput("t1_pushpop_count", 32'(bus.fifo_count), 32'd1);
        waitPulses(base + 1, 20, "t1_first_pulse");
        p = pulse_cycles[base];
        checkOutput("t1_issue_latency", 32'(p), 32'(c0 + 2));
        waitCycle(p + 2);
        bus.stepper_busy = 1'b1;
        waitCycle(p + 12);
        bus.stepper_busy = 1'b0;
        waitPulses(base + 2, 100, "t1_second_pulse");
        checkOutput("t1_settle_gap", 32'(pulse_cycles[base + 1]), 32'(p + 35));
        waitIdle(100, "t1_idle");

        // Test 3: null moves; start timeout 16 + settle 20 + 2 => 38 cycles apart
        $display("[TB] test 3: null move start timeout");
        exp_q.push_back(32'h0060_1234);
        exp_q.push_back(32'h0000_0300);
        base = pulse_count;
        applyStimulus(1, 32'h0060_1234, c0);
        applyStimulus(0, 32'h0000_0300, c1);
        waitPulses(base + 2, 120, "t3_pulses");
        checkOutput("t3_issue_latency", 32'(pulse_cycles[base]), 32'(c0 + 2));
        checkOutput("t3_timeout_gap", 32'(pulse_cycles[base + 1] - pulse_cycles[base]), 32'd38);
        waitIdle(100, "t3_idle");

        // Test 2: both requesters streaming. Four pushes so far leave the
        // round-robin pointer at requester 0, so order is 0,1,0,1,...
        $display("[TB] test 2: round-robin with full FIFO");
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(32'h0000_1000 + 32'(k));
            exp_q.push_back(32'h0000_2000 + 32'(k));
        end
        base     = pulse_count;
        done0    = 1'b0;
        done1    = 1'b0;
        saw_full = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) applyStimulus(0, 32'h0000_1000 + 32'(k), acc0[k]);
                done0 = 1'b1;
            end
            begin
                for (int k = 0; k < 6; k++) applyStimulus(1, 32'h0000_2000 + 32'(k), acc1[k]);
                done1 = 1'b1;
            end
            begin
                while (!(done0 && done1)) begin
                    @(negedge CLK100MHZ);
                    if (bus.fifo_count == 3'(DEPTH)) begin
                        saw_full = 1'b1;
                        checkOutput("t2_full_ready0", bus.req0_ready, 1'b0);
                        checkOutput("t2_full_ready1", bus.req1_ready, 1'b0);
                    end
                end
            end
        join
        checkOutput("t2_reached_full", saw_full, 1'b1);
        for (int k = 0; k < 6; k++) begin
            checkOutput("t2_order_0_before_1", 32'(acc0[k] < acc1[k]), 32'd1);
            if (k < 5) checkOutput("t2_order_1_before_0", 32'(acc1[k] < acc0[k + 1]), 32'd1);
        end
        waitPulses(base + 12, 12 * 45, "t2_pulses");
        waitIdle(100, "t2_idle");

        // Test 4: abort during WAIT_DONE with three commands still queued
        $display("[TB] test 4: abort flushes queue");
        exp_q.push_back(32'h0000_0401);
        exp_q.push_back(ABORT_CMD);
        base = pulse_count;
        applyStimulus(0, 32'h0000_0401, c0);
        applyStimulus(0, 32'h0000_0402, c1);
        applyStimulus(0, 32'h0000_0403, c2);
        applyStimulus(0, 32'h0000_0404, c3);
        waitPulses(base + 1, 20, "t4_first_pulse");
        p = pulse_cycles[base];
        waitCycle(p + 1);
        bus.stepper_busy = 1'b1;
        waitCycle(p + 4);
        checkOutput("t4_queued_count", 32'(bus.fifo_count), 32'd3);
        bus.abort = 1'b1;
        waitCycle(p + 5);
        a = cycle;
        bus.abort        = 1'b0;
        bus.stepper_busy = 1'b0;
        checkOutput("t4_flushed_count", 32'(bus.fifo_count), 32'd0);
        waitPulses(base + 2, 20, "t4_abort_pulse");
        checkOutput("t4_abort_pulse_cycle", 32'(pulse_cycles[base + 1]), 32'(a + 1));
        waitIdle(100, "t4_idle");
        waitCycle(cycle + 10);
        checkOutput("t4_no_queued_issue", 32'(pulse_count), 32'(base + 2));

        // Test 5: same-cycle push/pop at count 1, fill to full, then reset
        $display("[TB] test 5: push/pop at count 1, fill, reset");
        exp_q.push_back(32'h0000_0501);
        base = pulse_count;
        applyStimulus(0, 32'h0000_0501, c0);
        applyStimulus(1, 32'h0000_0502, c1);
        checkOutput("t5_pushpop_count", 32'(bus.fifo_count), 32'd1);
        applyStimulus(0, 32'h0000_0503, c2);
        applyStimulus(1, 32'h0000_0504, c3);
        applyStimulus(0, 32'h0000_0505, c4);
        checkOutput("t5_full_count", 32'(bus.fifo_count), 32'd4);
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'h0000_05FF;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 32'h0000_05FE;
        @(negedge CLK100MHZ);
        checkOutput("t5_full_ready0", bus.req0_ready, 1'b0);
        checkOutput("t5_full_ready1", bus.req1_ready, 1'b0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset = 1'b1;
        waitCycle(cycle + 1);
        checkOutput("t5_rst_count",    32'(bus.fifo_count), 32'd0);
        checkOutput("t5_rst_idle",     bus.idle, 1'b1);
        checkOutput("t5_rst_new_data", bus.cmd_new_data, 1'b0);
        checkOutput("t5_rst_cmd_data", bus.cmd_data, 32'h0);
        waitCycle(cycle + 2);
        reset = 1'b0;
        waitCycle(cycle + 60);
        checkOutput("t5_no_pulse_after_reset", 32'(pulse_count), 32'(base + 1));

        // Test 6: abort coincident with a req0 push drops the push
        $display("[TB] test 6: abort with concurrent push");
        exp_q.push_back(ABORT_CMD);
        base = pulse_count;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'h0000_0601;
        bus.abort      = 1'b1;
        @(negedge CLK100MHZ);
        checkOutput("t6_ready0_abort", bus.req0_ready, 1'b0);
        waitCycle(cycle + 1);
        a = cycle;
        bus.abort      = 1'b0;
        bus.req0_valid = 1'b0;
        checkOutput("t6_count", 32'(bus.fifo_count), 32'd0);
        waitPulses(base + 1, 20, "t6_abort_pulse");
        checkOutput("t6_abort_pulse_cycle", 32'(pulse_cycles[base]), 32'(a + 1));
        waitIdle(100, "t6_idle");
        waitCycle(cycle + 10);
        checkOutput("t6_pulse_total", 32'(pulse_count), 32'(base + 1));

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
